// File: rtl/e_pkg.sv
// -----------------------------------------------------------------------------
// e_pkg
// Shared widths and types for the 4-to-2 MSB-first priority encoder (blk_741a70).
//   IN_W  : request vector width (4)
//   OUT_W : encoded index width (2)
//   req_t : request vector type
//   idx_t : encoded index type
// -----------------------------------------------------------------------------
package e_pkg;

    localparam int IN_W  = 4;
    localparam int OUT_W = 2;

    typedef logic [IN_W-1:0]  req_t;
    typedef logic [OUT_W-1:0] idx_t;

endpackage : e_pkg

// File: rtl/e_prio_enc.sv
// -----------------------------------------------------------------------------
// e_prio_enc
// Purely combinational MSB-first priority encoder.
// Ports:
//   i_req : input  req_t  request vector, bit 3 has highest priority
//   o_idx : output idx_t  index of the highest set bit (0 when nothing is set)
//   o_any : output logic  any bit of i_req set
// -----------------------------------------------------------------------------
module e_prio_enc
    import e_pkg::*;
(
    input  req_t i_req,
    output idx_t o_idx,
    output logic o_any
);

    // Priority decode. The if/else chain tests the highest bit first, so bits
    // below the winning one are never looked at and cannot inject X.
    always_comb begin
        o_idx = 2'd0;
        if (i_req[3] == 1'b1) begin
            o_idx = 2'd3;
        end else if (i_req[2] == 1'b1) begin
            o_idx = 2'd2;
        end else if (i_req[1] == 1'b1) begin
            o_idx = 2'd1;
        end else begin
            o_idx = 2'd0;
        end
    end

    // Any-set flag.
    always_comb begin
        o_any = |i_req;
    end

endmodule : e_prio_enc

// File: rtl/blk_741a70.sv
// -----------------------------------------------------------------------------
// blk_741a70
// Registered 4-to-2 MSB-first priority encoder with sample enable.
// Optional feature macro: E_VALID_EN -- when defined, adds the registered
// "any bit set" output vld; when undefined, vld and its register are absent.
// Ports:
//   clk : input  1  clock, rising edge
//   rst : input  1  asynchronous active-high reset, clears y (and vld)
//   en  : input  1  sample enable; outputs hold while low
//   a   : input  4  request vector, bit 3 highest priority
//   y   : output 2  registered index of the highest set bit of a
//   vld : output 1  registered (a != 0); only with E_VALID_EN
// -----------------------------------------------------------------------------
module blk_741a70
    import e_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  a,
`ifdef E_VALID_EN
    output logic             vld,
`endif
    output logic [OUT_W-1:0] y
);

    idx_t w_idx;
    logic w_any;
    idx_t r_y;

    e_prio_enc u_prio_enc (
        .i_req (a),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Index register: async clear, load on enable, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y <= 2'd0;
        end else if (en) begin
            r_y <= w_idx;
        end else begin
            r_y <= r_y;
        end
    end

    assign y = r_y;

`ifdef E_VALID_EN
    logic r_vld;

    // Any-set register: same load/hold/clear behaviour as the index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
        end else if (en) begin
            r_vld <= w_any;
        end else begin
            r_vld <= r_vld;
        end
    end

    assign vld = r_vld;
`else
    // The any-set flag has no consumer in this build.
    logic w_unused_any;
    assign w_unused_any = w_any;
`endif

endmodule : blk_741a70

// File: tb/tb_blk_741a70.sv
// -----------------------------------------------------------------------------
// tb_blk_741a70
// Scoreboard bench for blk_741a70: the driver pushes the hand-computed
// expected output for each edge; a monitor pops and compares on the falling
// edge (or on an explicit trigger for the asynchronous reset case).
// Works with and without E_VALID_EN.
// -----------------------------------------------------------------------------
module tb_blk_741a70;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] a;
    logic [1:0] y;
    logic       vld;

    typedef struct {
        logic [1:0] y;
        logic       v;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;
    event sample_ev;

    blk_741a70 dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a),
`ifdef E_VALID_EN
        .vld (vld),
`endif
        .y   (y)
    );

`ifndef E_VALID_EN
    assign vld = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compare the oldest expectation against the outputs.
    always @(negedge clk or sample_ev) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (y !== e.y) begin
                errors++;
                $display("FAIL %s: y=%b expected %b", e.name, y, e.y);
            end
`ifdef E_VALID_EN
            checks++;
            if (vld !== e.v) begin
                errors++;
                $display("FAIL %s_vld: vld=%b expected %b", e.name, vld, e.v);
            end
`endif
        end
    end

    // Drive one sample, let it be captured, queue the expected result.
    task automatic step(input logic [3:0] av, input logic ev,
                        input logic [1:0] ey, input logic evld, input string nm);
        exp_t e;
        a  = av;
        en = ev;
        @(posedge clk);
        e.y = ey; e.v = evld; e.name = nm;
        q.push_back(e);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [3:0] ax;
        rst = 1'b1;
        en  = 1'b0;
        a   = 4'b0000;

        // Outputs cleared while reset is held.
        @(posedge clk); #1;
        e.y = 2'd0; e.v = 1'b0; e.name = "reset_state";
        q.push_back(e);
        @(posedge clk); #1;
        rst = 1'b0;

        // Release and basic encoding.
        step(4'b0000, 1'b1, 2'd0, 1'b0, "zero");
        step(4'b0001, 1'b1, 2'd0, 1'b1, "a0001");
        step(4'b0011, 1'b1, 2'd1, 1'b1, "a0011");
        step(4'b0111, 1'b1, 2'd2, 1'b1, "a0111");
        ax = 4'b1xxx;
        step(ax,      1'b1, 2'd3, 1'b1, "a1xxx");

        // Hold while enable is low.
        step(4'b0111, 1'b1, 2'd2, 1'b1, "load0111");
        step(4'b1000, 1'b0, 2'd2, 1'b1, "hold1");
        step(4'b1000, 1'b0, 2'd2, 1'b1, "hold2");
        step(4'b1000, 1'b0, 2'd2, 1'b1, "hold3");
        step(4'b1000, 1'b1, 2'd3, 1'b1, "release_hold");

        // More patterns, including back to zero.
        step(4'b0000, 1'b1, 2'd0, 1'b0, "zero_again");
        step(4'b0101, 1'b1, 2'd2, 1'b1, "a0101");
        step(4'b0010, 1'b1, 2'd1, 1'b1, "a0010");
        step(4'b1111, 1'b1, 2'd3, 1'b1, "a1111");

        // Asynchronous reset between edges while y=3, with a pending sample.
        @(negedge clk); #2;
        a   = 4'b1000;
        en  = 1'b1;
        rst = 1'b1;
        #1;
        e.y = 2'd0; e.v = 1'b0; e.name = "async_reset";
        q.push_back(e);
        -> sample_ev;
        @(posedge clk); #1;
        rst = 1'b0;

        // First enabled edge after reset loads normally, then hold.
        step(4'b0010, 1'b1, 2'd1, 1'b1, "post_reset");
        step(4'b0000, 1'b0, 2'd1, 1'b1, "post_reset_hold");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected %0d", q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time=%0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_blk_741a70

// File: doc/blk_741a70.md
E -- requirements
Module: e

Interface
- REQ-001: Parameters: none; widths fixed at 4-bit input and 2-bit output, taken from e_pkg.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst  input  1  reset, asynchronous and active-high.
- REQ-004: en  input  1  sample enable; when low, registered outputs hold.
- REQ-005: a  input  4  request vector; bit 3 has highest priority.
- REQ-006: y  output  2  registered index of highest set bit of a.
- REQ-007: vld  output  1  registered "any bit of a set"; present only with E_VALID_EN.

Function
- REQ-008: Encoding is MSB-first priority, decided by the highest set bit only:
  - a[3]=1 -> y=3
  - a[3:2]=01 -> y=2
  - a[3:1]=001 -> y=1
  - a=0001 -> y=0
  - a=0000 -> y=0
- REQ-009: Bits below the highest set bit are don't-care, including X/Z; e.g. a=1xxx SHALL yield y=3.
- REQ-010: Latency is exactly one clk cycle: a sampled at edge N with en=1 appears on y (and vld) after edge N.
- REQ-011: With en=0 at an edge, y and vld keep their previous values.
- REQ-012: vld = 1 iff a != 0 at the sampling edge.
- REQ-013: Encoding is purely combinational ahead of the output register; no other state exists.
- REQ-014: No X SHALL propagate to y when a[3]=1, regardless of a[2:0].

Reset
- REQ-015: While rst=1, y=2'b00 and vld=0, immediately and independently of clk.
- REQ-016: Reset asserted mid-operation clears the outputs asynchronously; any pending sample is discarded.
- REQ-017: After rst deasserts, the first rising edge with en=1 loads normally.

Configuration
- REQ-018: Macro E_VALID_EN:
  - Defined: port vld exists and its register is implemented per REQ-012.
  - Undefined: vld port and its register are omitted; y behaviour is unchanged, with a=0000 still giving y=0.

Structure
- REQ-019: Package e_pkg holds:
  - localparam IN_W=4 and OUT_W=2
  - typedef req_t (logic [IN_W-1:0]) and idx_t (logic [OUT_W-1:0])
- REQ-020: One combinational sub-module, e_prio_enc, maps req_t to idx_t plus an any-set flag; e instantiates it and adds the output registers.

Verification
- REQ-021: Assert rst, then release with a=0000, en=1 -> y=0 (vld=0) after one edge.
- REQ-022: Apply a=0001, 0011, 0111 on consecutive edges -> y=0, 1, 2 each one cycle later (vld=1).
- REQ-023: Apply a=1xxx -> y=3 after one edge, no X on y.
- REQ-024: Load a=0111, then en=0 with a=1000 for 3 edges -> y stays 2; en=1 -> y=3.
- REQ-025: Assert rst asynchronously mid-cycle while y=3 -> y=0 (vld=0) before the next edge.
- REQ-026: Build without E_VALID_EN and rerun REQ-021 to REQ-024 -> identical y sequence, vld port absent.
